// File: rtl/playback_sequencer.sv
// Transport controller for the music player: play/pause/stop/repeat/skip
// over a beat index that advances on rising edges of play_clk.
module playback_sequencer #(
  parameter int LEN   = 512,
  parameter int IDX_W = 9,
  parameter int SKIP  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play_clk,
  input  logic             play_1p,
  input  logic             stop_1p,
  input  logic             fwd_1p,
  input  logic             back_1p,
  input  logic             repeat_en,
  output logic [IDX_W-1:0] beat_idx,
  output logic             playing,
  output logic [1:0]       state,
  output logic             done_pulse,
  output logic             wrap_pulse
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W:0] W_LAST = (IDX_W+1)'(LEN - 1);
  localparam logic [IDX_W:0] W_SKIP = (IDX_W+1)'(SKIP);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_playing;
  logic             r_done;
  logic             r_wrap;
  logic             r_pclk_d;

  logic             w_tick;
  logic             w_skip_f;
  logic             w_skip_b;
  logic             w_skip;
  logic             w_at_end;
  logic [IDX_W:0]   w_fwd_sum;
  logic [IDX_W-1:0] w_fwd_sat;
  logic [IDX_W-1:0] w_back_sat;
  logic [IDX_W-1:0] w_skip_idx;

  assign w_tick   = play_clk & ~r_pclk_d;
  // Simultaneous fwd and back cancel each other out.
  assign w_skip_f = fwd_1p & ~back_1p;
  assign w_skip_b = back_1p & ~fwd_1p;
  assign w_skip   = w_skip_f | w_skip_b;
  assign w_at_end = ({1'b0, r_idx} == W_LAST);

  // One extra bit keeps the forward sum from wrapping before saturation.
  assign w_fwd_sum  = {1'b0, r_idx} + W_SKIP;
  assign w_fwd_sat  = (w_fwd_sum > W_LAST) ? W_LAST[IDX_W-1:0]
                                           : w_fwd_sum[IDX_W-1:0];
  assign w_back_sat = ({1'b0, r_idx} < W_SKIP) ? '0
                                               : r_idx - W_SKIP[IDX_W-1:0];
  assign w_skip_idx = w_skip_f ? w_fwd_sat : w_back_sat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_STOP;
      r_idx     <= '0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
      r_pclk_d  <= 1'b1;
    end else begin
      r_pclk_d <= play_clk;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
      unique case (r_state)
        ST_STOP: begin
          r_idx <= '0;
          if (!stop_1p && play_1p) begin
            r_state   <= ST_PLAY;
            r_playing <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (stop_1p) begin
            r_state   <= ST_STOP;
            r_idx     <= '0;
            r_playing <= 1'b0;
          end else if (play_1p) begin
            r_state   <= ST_PAUSE;
            r_playing <= 1'b0;
          end else if (w_skip) begin
            r_idx <= w_skip_idx;
          end else if (w_tick) begin
            if (!w_at_end) begin
              r_idx <= r_idx + 1'b1;
            end else if (repeat_en) begin
              r_idx  <= '0;
              r_wrap <= 1'b1;
            end else begin
              r_state   <= ST_DONE;
              r_playing <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (stop_1p) begin
            r_state <= ST_STOP;
            r_idx   <= '0;
          end else if (play_1p) begin
            r_state   <= ST_PLAY;
            r_playing <= 1'b1;
          end else if (w_skip) begin
            r_idx <= w_skip_idx;
          end
        end
        ST_DONE: begin
          if (stop_1p) begin
            r_state <= ST_STOP;
            r_idx   <= '0;
          end else if (play_1p) begin
            r_state   <= ST_PLAY;
            r_idx     <= '0;
            r_playing <= 1'b1;
          end else begin
            r_idx <= W_LAST[IDX_W-1:0];
          end
        end
        default: begin
          r_state   <= ST_STOP;
          r_idx     <= '0;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

  assign beat_idx   = r_idx;
  assign playing    = r_playing;
  assign state      = r_state;
  assign done_pulse = r_done;
  assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed and randomized bench for playback_sequencer (LEN=8, SKIP=3)
// against a behavioural transport model.
module tb_playback_sequencer;

  localparam int LEN   = 8;
  localparam int IDX_W = 3;
  localparam int SKIP  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             play_clk;
  logic             play_1p;
  logic             stop_1p;
  logic             fwd_1p;
  logic             back_1p;
  logic             repeat_en;
  logic [IDX_W-1:0] beat_idx;
  logic             playing;
  logic [1:0]       state;
  logic             done_pulse;
  logic             wrap_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  // model: 0=STOP 1=PLAY 2=PAUSE 3=DONE
  int m_state;
  int m_idx;
  int m_done;
  int m_wrap;
  int m_prev_pc;

  playback_sequencer #(
    .LEN   (LEN),
    .IDX_W (IDX_W),
    .SKIP  (SKIP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .play_clk   (play_clk),
    .play_1p    (play_1p),
    .stop_1p    (stop_1p),
    .fwd_1p     (fwd_1p),
    .back_1p    (back_1p),
    .repeat_en  (repeat_en),
    .beat_idx   (beat_idx),
    .playing    (playing),
    .state      (state),
    .done_pulse (done_pulse),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit pc, input bit p,
                            input bit s, input bit f, input bit b,
                            input bit rep);
    bit tick;
    bit sk;
    int target;
    m_done = 0;
    m_wrap = 0;
    if (!r) begin
      m_state   = 0;
      m_idx     = 0;
      m_prev_pc = 1;
      return;
    end
    tick      = pc && (m_prev_pc == 0);
    m_prev_pc = pc;
    sk        = f ^ b;
    target    = f ? ((m_idx + SKIP > LEN - 1) ? LEN - 1 : m_idx + SKIP)
                  : ((m_idx - SKIP < 0) ? 0 : m_idx - SKIP);
    if (s) begin
      m_state = 0;
      m_idx   = 0;
    end else if (m_state == 0) begin
      m_idx = 0;
      if (p) m_state = 1;
    end else if (m_state == 3) begin
      if (p) begin
        m_state = 1;
        m_idx   = 0;
      end
    end else if (p) begin
      m_state = (m_state == 1) ? 2 : 1;
    end else if (sk) begin
      m_idx = target;
    end else if (tick && m_state == 1) begin
      if (m_idx < LEN - 1) m_idx++;
      else if (rep) begin
        m_idx  = 0;
        m_wrap = 1;
      end else begin
        m_state = 3;
        m_done  = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit pc, input bit p, input bit s,
                      input bit f, input bit b, input bit rep);
    rst       = r;
    play_clk  = pc;
    play_1p   = p;
    stop_1p   = s;
    fwd_1p    = f;
    back_1p   = b;
    repeat_en = rep;
    model_step(r, pc, p, s, f, b, rep);
    @(posedge clk);
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("beat_idx", 32'(beat_idx), 32'(m_idx));
    chk("playing", 32'(playing), 32'(m_state == 1));
    chk("done_pulse", 32'(done_pulse), 32'(m_done));
    chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
    chk("pulse_excl", 32'(done_pulse & wrap_pulse), 32'd0);
  endtask

  task automatic idle(input bit pc, input bit rep);
    step(1, pc, 0, 0, 0, 0, rep);
  endtask

  task automatic tick_once(input bit rep);
    idle(0, rep);
    idle(1, rep);
  endtask

  initial begin
    rst = 0; play_clk = 0; play_1p = 0; stop_1p = 0;
    fwd_1p = 0; back_1p = 0; repeat_en = 0;
    @(posedge clk);
    #1;

    // 1: play through to DONE
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_idx", 32'(beat_idx), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("t1_play", 32'(state), 32'd1);
    for (int i = 1; i < LEN; i++) begin
      tick_once(0);
      chk("t1_step", 32'(beat_idx), 32'(i));
    end
    tick_once(0);
    chk("t1_done_state", 32'(state), 32'd3);
    chk("t1_done_pulse", 32'(done_pulse), 32'd1);
    chk("t1_done_idx", 32'(beat_idx), 32'd7);
    idle(0, 0);
    chk("t1_pulse_once", 32'(done_pulse), 32'd0);
    chk("t1_hold_idx", 32'(beat_idx), 32'd7);

    // 2: repeat wrap
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 1);
    for (int i = 1; i < LEN; i++) tick_once(1);
    chk("t2_at7", 32'(beat_idx), 32'd7);
    tick_once(1);
    chk("t2_wrap_idx", 32'(beat_idx), 32'd0);
    chk("t2_wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("t2_state", 32'(state), 32'd1);

    // 3: pause holds index
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick_once(0);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("t3_pause", 32'(state), 32'd2);
    for (int i = 0; i < 5; i++) tick_once(0);
    chk("t3_held", 32'(beat_idx), 32'd3);
    step(1, 0, 1, 0, 0, 0, 0);
    tick_once(0);
    chk("t3_resume", 32'(beat_idx), 32'd4);

    // 4: skip saturation
    tick_once(0);
    tick_once(0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("t4_fwd_sat", 32'(beat_idx), 32'd7);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("t4_fwd_hold", 32'(beat_idx), 32'd7);
    chk("t4_no_done", 32'(state), 32'd1);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    tick_once(0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("t4_back_sat", 32'(beat_idx), 32'd0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("t4_stop_fwd", 32'(beat_idx), 32'd0);
    chk("t4_stop_state", 32'(state), 32'd0);

    // 5: stop beats play and tick
    step(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick_once(0);
    idle(0, 0);
    step(1, 1, 1, 1, 0, 0, 0);
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_idx", 32'(beat_idx), 32'd0);
    chk("t5_pulses", 32'({done_pulse, wrap_pulse}), 32'd0);

    // 6: reset mid-play with play_clk high
    step(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick_once(0);
    chk("t6_pre", 32'(beat_idx), 32'd4);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_idx", 32'(beat_idx), 32'd0);
    step(1, 1, 1, 0, 0, 0, 0);
    idle(1, 0);
    idle(1, 0);
    chk("t6_no_tick", 32'(beat_idx), 32'd0);
    chk("t6_playing", 32'(playing), 32'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) != 0),
           $urandom_range(1),
           ($urandom_range(11) == 0),
           ($urandom_range(29) == 0),
           ($urandom_range(9) == 0),
           ($urandom_range(9) == 0),
           $urandom_range(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
